// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a 32-bit little-endian memory.
// Define MAU_SUBWORD_EN to enable byte/halfword loads and read-modify-write stores.
module mem_access_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ACC,
        ST_RD,
        ST_WR,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] merge;
    logic [31:0] rdata;
    logic        err;

    logic        req_any;
    logic        req_word;
    logic        req_mis;
    logic [31:0] ld_val;

`ifdef MAU_SUBWORD_EN
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_wdata;
    logic [4:0]  shamt;
    logic [15:0] lane;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] st_val;
`else
    logic        unused;
`endif

    assign req_any  = load_i | store_i;
    assign req_word = (size_i == 2'b10);

`ifdef MAU_SUBWORD_EN
    always_comb begin
        req_mis = 1'b0;
        unique case (size_i)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = addr_i[0];
            2'b10:   req_mis = |addr_i[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    // Halfwords are aligned, so the byte-lane shift also selects the half lane.
    assign shamt = {req_addr[1:0], 3'b000};
    assign lane  = 16'(mem_data_i >> shamt);

    always_comb begin
        ld_val = mem_data_i;
        unique case (req_size)
            2'b00:   ld_val = {{24{~req_unsigned & lane[7]}}, lane[7:0]};
            2'b01:   ld_val = {{16{~req_unsigned & lane[15]}}, lane};
            default: ld_val = mem_data_i;
        endcase
    end

    assign lane_mask = (req_size == 2'b00 ? 32'h0000_00ff
                                          : 32'h0000_ffff) << shamt;
    assign lane_data = (req_size == 2'b00) ? {4{req_wdata[7:0]}}
                                           : {2{req_wdata}};
    assign st_val    = (mem_data_i & ~lane_mask) | (lane_data & lane_mask);
`else
    assign req_mis = ~req_word | (|addr_i[1:0]);
    assign ld_val  = mem_data_i;
    assign unused  = ^{unsigned_i, req_addr[1:0]};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            req_addr <= '0;
            merge    <= '0;
            rdata    <= '0;
            err      <= 1'b0;
`ifdef MAU_SUBWORD_EN
            req_size     <= '0;
            req_unsigned <= 1'b0;
            req_wdata    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        req_addr <= addr_i;
                        merge    <= wdata_i;
                        rdata    <= '0;
                        err      <= req_mis;
`ifdef MAU_SUBWORD_EN
                        req_size     <= size_i;
                        req_unsigned <= unsigned_i;
                        req_wdata    <= wdata_i[15:0];
`endif
                        if (req_mis)
                            state <= DONE;
                        else if (store_i)
                            state <= req_word ? ST_WR : ST_RD;
                        else
                            state <= LD_ACC;
                    end
                end
                LD_ACC: begin
                    rdata <= ld_val;
                    state <= DONE;
                end
`ifdef MAU_SUBWORD_EN
                ST_RD: begin
                    merge <= st_val;
                    state <= ST_WR;
                end
`endif
                ST_WR:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o     = (state != DONE) & ((state != IDLE) | req_any);
    assign mem_read_o  = (state == LD_ACC) | (state == ST_RD);
    assign mem_write_o = (state == ST_WR);
    assign mem_data_o  = mem_write_o ? merge : '0;
    assign mem_addr_o  = (state == IDLE) ? '0 : {req_addr[31:2], 2'b00};
    assign rdata_o     = rdata;
    assign misalign_o  = err & (state == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven scoreboard bench for mem_access_unit.
// Expectations follow MAU_SUBWORD_EN (sub-word accesses misalign when undefined).
module tb_mem_access_unit;

`ifdef MAU_SUBWORD_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        load_i;
    logic        store_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        misalign_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    logic [31:0] mem [16];
    logic        mem_init;
    int          overlap = 0;

    mem_access_unit dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .load_i     (load_i),
        .store_i    (store_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_data_i (mem_data_i)
    );

    always #5 clk = ~clk;

    assign mem_data_i = mem[mem_addr_o[5:2]];

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 4) ? 32'h8899_AABB : 32'h0;
        end else if (mem_write_o) begin
            mem[mem_addr_o[5:2]] <= mem_data_o;
        end
        if (mem_read_o && mem_write_o)
            overlap <= overlap + 1;
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] e_rdata;
        logic        e_mis;
        int          e_cyc;
        int          e_rd;
        int          e_wr;
        logic        chk;
        logic [31:0] e_mem;
    } vec_t;

    vec_t vecs [22];
    vec_t exp_q [$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t ldv(input logic [31:0] a, input logic [1:0] sz,
                                 input logic u, input logic [31:0] r,
                                 input bit ok);
        vec_t v;
        v.ld = 1'b1; v.st = 1'b0; v.addr = a; v.wdata = 32'h0;
        v.size = sz; v.uns = u;
        v.e_rdata = ok ? r : 32'h0;
        v.e_mis = ~ok;
        v.e_cyc = ok ? 3 : 2;
        v.e_rd = ok ? 1 : 0;
        v.e_wr = 0;
        v.chk = 1'b0; v.e_mem = 32'h0;
        return v;
    endfunction

    function automatic vec_t stv(input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic both,
                                 input bit ok, input logic [31:0] m);
        vec_t v;
        v.ld = both; v.st = 1'b1; v.addr = a; v.wdata = wd;
        v.size = sz; v.uns = 1'b0;
        v.e_rdata = 32'h0;
        v.e_mis = ~ok;
        v.e_cyc = ok ? ((sz == 2'b10) ? 3 : 4) : 2;
        v.e_rd = (ok && sz != 2'b10) ? 1 : 0;
        v.e_wr = ok ? 1 : 0;
        v.chk = 1'b1; v.e_mem = m;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, input int id);
        vec_t e;
        int   cyc = 0;
        int   rd = 0;
        int   wr = 0;
        bit   done = 1'b0;
        load_i = v.ld; store_i = v.st; addr_i = v.addr;
        wdata_i = v.wdata; size_i = v.size; unsigned_i = v.uns;
        exp_q.push_back(v);
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (mem_read_o) rd++;
            if (mem_write_o) wr++;
            if (mem_read_o || mem_write_o)
                check32($sformatf("v%0d mem_addr", id), mem_addr_o,
                        {v.addr[31:2], 2'b00});
            if (!stall_o) begin
                done = 1'b1;
                e = exp_q.pop_front();
                check32($sformatf("v%0d rdata", id), rdata_o, e.e_rdata);
                check32($sformatf("v%0d misalign", id),
                        {31'b0, misalign_o}, {31'b0, e.e_mis});
                check32($sformatf("v%0d cycles", id), 32'(cyc), 32'(e.e_cyc));
                check32($sformatf("v%0d reads", id), 32'(rd), 32'(e.e_rd));
                check32($sformatf("v%0d writes", id), 32'(wr), 32'(e.e_wr));
                if (e.chk)
                    check32($sformatf("v%0d mem", id), mem[e.addr[5:2]],
                            e.e_mem);
            end else if (cyc >= 8) begin
                done = 1'b1;
                e = exp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL v%0d timeout: stall_o still 1 after %0d cycles, expected low by %0d",
                         id, cyc, e.e_cyc);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        load_i = 1'b0; store_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = ldv(32'h11, 2'b00, 1'b0, 32'hFFFF_FFAA, SW);
        vecs[1]  = ldv(32'h11, 2'b00, 1'b1, 32'h0000_00AA, SW);
        vecs[2]  = ldv(32'h12, 2'b01, 1'b0, 32'hFFFF_8899, SW);
        vecs[3]  = ldv(32'h10, 2'b10, 1'b0, 32'h8899_AABB, 1'b1);
        vecs[4]  = ldv(32'h13, 2'b01, 1'b0, 32'h0, 1'b0);
        vecs[5]  = ldv(32'h10, 2'b01, 1'b1, 32'h0000_AABB, SW);
        vecs[6]  = ldv(32'h10, 2'b00, 1'b0, 32'hFFFF_FFBB, SW);
        vecs[7]  = ldv(32'h13, 2'b00, 1'b1, 32'h0000_0088, SW);
        vecs[8]  = ldv(32'h12, 2'b10, 1'b0, 32'h0, 1'b0);
        vecs[9]  = ldv(32'h10, 2'b11, 1'b0, 32'h0, 1'b0);
        vecs[10] = stv(32'h08, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs[11] = ldv(32'h08, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1);
        vecs[12] = stv(32'h0C, 32'h1234_5678, 2'b10, 1'b1, 1'b1, 32'h1234_5678);
        vecs[13] = stv(32'h0E, 32'h0000_CAFE, 2'b01, 1'b0, SW,
                       SW ? 32'hCAFE_5678 : 32'h1234_5678);
        vecs[14] = ldv(32'h0E, 2'b01, 1'b0, 32'hFFFF_CAFE, SW);
        vecs[15] = stv(32'h0B, 32'hFFFF_FFA5, 2'b00, 1'b0, SW,
                       SW ? 32'hA5AD_BEEF : 32'hDEAD_BEEF);
        vecs[16] = ldv(32'h0B, 2'b00, 1'b0, 32'hFFFF_FFA5, SW);
        vecs[17] = stv(32'h12, 32'h0000_0055, 2'b00, 1'b0, SW,
                       SW ? 32'h8855_AABB : 32'h8899_AABB);
        vecs[18] = ldv(32'h10, 2'b10, 1'b0,
                       SW ? 32'h8855_AABB : 32'h8899_AABB, 1'b1);
        vecs[19] = stv(32'h10, 32'h0, 2'b11, 1'b0, 1'b0,
                       SW ? 32'h8855_AABB : 32'h8899_AABB);
        vecs[20] = ldv(32'h12, 2'b00, 1'b0, 32'h0000_0055, SW);
        vecs[21] = ldv(32'h10, 2'b10, 1'b0,
                       SW ? 32'h8855_AABB : 32'h8899_AABB, 1'b1);

        rst_i = 1'b1; mem_init = 1'b1;
        load_i = 1'b0; store_i = 1'b0; addr_i = '0; wdata_i = '0;
        size_i = 2'b10; unsigned_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0; mem_init = 1'b0;

        check32("rst stall", {31'b0, stall_o}, 32'h0);
        check32("rst rdata", rdata_o, 32'h0);
        check32("rst misalign", {31'b0, misalign_o}, 32'h0);
        check32("rst mem_read", {31'b0, mem_read_o}, 32'h0);
        check32("rst mem_write", {31'b0, mem_write_o}, 32'h0);
        check32("rst mem_data", mem_data_o, 32'h0);
        check32("rst mem_addr", mem_addr_o, 32'h0);

        for (int i = 0; i < 22; i++)
            issue(vecs[i], i);

        // Reset lands while the access is in flight (ST_RD or LD_ACC).
        load_i = ~SW; store_i = SW; addr_i = 32'h10;
        wdata_i = 32'h0000_0077; size_i = SW ? 2'b00 : 2'b10;
        unsigned_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1; load_i = 1'b0; store_i = 1'b0;
        @(negedge clk);
        check32("rstmid in_read", {31'b0, mem_read_o}, 32'h1);
        check32("rstmid no_write", {31'b0, mem_write_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check32("rstmid stall", {31'b0, stall_o}, 32'h0);
        check32("rstmid mem_read", {31'b0, mem_read_o}, 32'h0);
        check32("rstmid mem_write", {31'b0, mem_write_o}, 32'h0);
        check32("rstmid mem_addr", mem_addr_o, 32'h0);
        check32("rstmid mem_data", mem_data_o, 32'h0);
        check32("rstmid rdata", rdata_o, 32'h0);
        check32("rstmid misalign", {31'b0, misalign_o}, 32'h0);
        @(negedge clk);
        check32("rstmid mem", mem[4], SW ? 32'h8855_AABB : 32'h8899_AABB);

        check32("rw overlap", 32'(overlap), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the byte-addressed, little-endian, 32-bit data memory. Accepts load/store requests from the MEM stage, drives word-aligned read/write cycles on the memory port, performs byte/halfword lane extraction with sign/zero extension on loads, and read-modify-write merging on sub-word stores. Stalls the pipeline until each access completes.

## Interface
- No parameters.
- clk_i  in  1  clock; memory samples writes on the falling edge, this block updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  32  byte address of request.
- wdata_i  in  32  store data; byte/half in low bits.
- load_i  in  1  load request.
- store_i  in  1  store request; wins over load_i if both are high.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (misaligned).
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- rdata_o  out  32  load result, valid in DONE.
- stall_o  out  1  hold pipeline.
- misalign_o  out  1  access rejected.
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_data_o  out  32  write data to memory.
- mem_read_o  out  1  memory read enable.
- mem_write_o  out  1  memory write enable.
- mem_data_i  in  32  combinational read data from memory.

## Operation
- Registers: state, req_addr, req_size, req_unsigned, req_wdata, merge word, rdata, err.
- IDLE: a request is accepted when load_i|store_i. Inputs are latched and the next state is chosen:
  - misaligned → DONE with err=1
  - load → LD_ACC
  - word store → ST_WR
  - byte/half store → ST_RD
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11. A misaligned request issues no memory access.
- LD_ACC: mem_read_o=1. At the edge, the addressed lane is extracted from mem_data_i and extended into rdata → DONE.
  - Byte lane is addr[1:0], little-endian (lane 0 = bits 7:0).
  - Half lane is addr[1].
  - Sign extension uses the lane's MSB unless req_unsigned.
- ST_RD: mem_read_o=1. Capture mem_data_i, replace the addressed lane with the low byte/half of req_wdata, store into merge → ST_WR.
- ST_WR: mem_write_o=1, mem_data_o=merge (or req_wdata for word) → DONE.
- DONE: stall_o=0.
  - rdata_o holds the load result (0 for stores/errors).
  - misalign_o=err.
  - Next state is IDLE unconditionally. The pipeline advances this cycle, so the new request is seen in IDLE.
- stall_o = (state≠DONE) & (state≠IDLE | load_i | store_i).
- Request inputs are ignored outside IDLE.
- mem_addr_o is driven from req_addr in every non-IDLE state.
- mem_read_o and mem_write_o are never high together.

## Timing
- Reset values:
  - state IDLE.
  - rdata_o, misalign_o, mem_read_o, mem_write_o, mem_data_o, mem_addr_o = 0.
  - stall_o = 0 when no request is present.
- Cycles from request presentation to stall_o low (DONE cycle):
  - load 3
  - word store 3
  - sub-word store 4
  - misaligned 2
- Memory outputs are registered-state decodes, stable from the rising edge through the falling edge. The memory write completes at the ST_WR falling edge.
- Reset mid-operation:
  - Takes effect at the next rising edge; the state returns to IDLE.
  - A write in the current ST_WR cycle still completes at that falling edge.
  - An aborted ST_RD performs no write.
  - stall_o drops per the IDLE rule.
- Back-to-back requests: DONE → IDLE accepts the next request without a bubble beyond DONE.

## Configuration
- MAU_SUBWORD_EN defined: byte and halfword accesses are supported as above.
- MAU_SUBWORD_EN undefined:
  - ST_RD, lane extraction, extension and merge logic are removed.
  - Any size_i≠10 is treated as misaligned; unsigned_i is ignored.
  - Word accesses are unchanged.

## Test plan
- Memory word at 0x10 = 0x8899AABB. Load byte signed at 0x11 → rdata_o=0xFFFFFFAA in cycle 3. Unsigned → 0x000000AA.
- Load half signed at 0x12 → 0xFFFF8899. Load word at 0x10 → 0x8899AABB. Load half at 0x13 → misalign_o=1 in cycle 2, no mem_read_o pulse.
- Store byte 0x55 to 0x12 over 0x8899AABB → exactly one read cycle then one write of 0x8855AABB. stall_o is high for 3 cycles.
- Store word 0xDEADBEEF to 0x08 → no read cycle; mem_write_o high for 1 cycle; readback 0xDEADBEEF.
- load_i and store_i both high → store performed, rdata_o=0. Back-to-back load after a store → second access starts the cycle after DONE.
- rst_i asserted during ST_RD of a byte store → no write occurs, memory is unchanged, outputs return to reset values next cycle.
